// File: rtl/ysyx_23060236_btb_pkg.sv
// Shared definitions for the branch target buffer.
//   BTB_ADDR_W / BTB_IDX_W : default PC width and index width
//   btb_state_e            : sweep FSM encoding (BTB_IDLE=0, BTB_CLEAR=1)
// Optional build macro YSYX_23060236_BTB_BYPASS_EN is consumed by the top level.
package ysyx_23060236_btb_pkg;
   localparam int BTB_ADDR_W = 25;
   localparam int BTB_IDX_W  = 4;

   typedef enum logic {
      BTB_IDLE  = 1'b0,
      BTB_CLEAR = 1'b1
   } btb_state_e;
endpackage

// File: rtl/ysyx_23060236_btb_if.sv
// Fetch/execute facing bundle of the branch target buffer.
//   lookup : req_valid/req_ready/req_pc -> resp_valid/resp_hit/resp_target
//   update : upd_valid/upd_pc/upd_target from execute
//   control: flush in, busy out (clear sweep running)
// Modport slave is the BTB, master is the core side.
interface ysyx_23060236_btb_if #(
   parameter int ADDR_W = ysyx_23060236_btb_pkg::BTB_ADDR_W
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_pc;
   logic              resp_valid;
   logic              resp_hit;
   logic [31:0]       resp_target;
   logic              upd_valid;
   logic [ADDR_W-1:0] upd_pc;
   logic [31:0]       upd_target;
   logic              flush;
   logic              busy;

   modport slave (
      input  req_valid, req_pc, upd_valid, upd_pc, upd_target, flush,
      output req_ready, resp_valid, resp_hit, resp_target, busy
   );
   modport master (
      output req_valid, req_pc, upd_valid, upd_pc, upd_target, flush,
      input  req_ready, resp_valid, resp_hit, resp_target, busy
   );
endinterface

// File: rtl/ysyx_23060236_btb_ram.sv
// Entry storage for the BTB: one synchronous write port, one combinational
// read port, no reset (validity lives in the top level).
//   clock       : write clock
//   we/widx/wdata : write port
//   ridx/rdata    : read port
module ysyx_23060236_btb_ram #(
   parameter int IDX_W  = 4,
   parameter int DATA_W = 51
) (
   input  logic              clock,
   input  logic              we,
   input  logic [IDX_W-1:0]  widx,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]  ridx,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [2**IDX_W];

   always_ff @(posedge clock) begin
      if (we) mem[widx] <= wdata;
   end

   assign rdata = mem[ridx];
endmodule

// File: rtl/ysyx_23060236_btb.sv
// Direct-mapped branch target buffer.
//   clock, reset : core clock, asynchronous active-high reset
//   bus (slave)  : lookup request/response, execute update, flush, busy
// A sequential sweep invalidates one entry per cycle after reset or flush;
// lookups are refused and updates dropped while it runs.
// Build macro YSYX_23060236_BTB_BYPASS_EN forwards a same-cycle update with
// matching index and tag straight to the lookup response.
module ysyx_23060236_btb
   import ysyx_23060236_btb_pkg::*;
#(
   parameter int ADDR_W = BTB_ADDR_W,
   parameter int IDX_W  = BTB_IDX_W,
   parameter int TAG_W  = ADDR_W - 2 - IDX_W
) (
   input  logic clock,
   input  logic reset,
   ysyx_23060236_btb_if.slave bus
);
   localparam int DATA_W = TAG_W + 32;

   btb_state_e          state_q, state_d;
   logic [IDX_W-1:0]    clr_idx_q, clr_idx_d;
   logic [2**IDX_W-1:0] valid_q;

   logic [IDX_W-1:0]  rd_idx, wr_idx;
   logic [TAG_W-1:0]  rd_tag, wr_tag;
   logic [DATA_W-1:0] rd_data;
   logic              upd_we, accept, hit_raw, hit;
   logic [31:0]       target;

   assign rd_idx = bus.req_pc[IDX_W+1:2];
   assign rd_tag = bus.req_pc[ADDR_W-1:IDX_W+2];
   assign wr_idx = bus.upd_pc[IDX_W+1:2];
   assign wr_tag = bus.upd_pc[ADDR_W-1:IDX_W+2];

   // flush beats a same-cycle update
   assign upd_we = (state_q == BTB_IDLE) & bus.upd_valid & ~bus.flush;
   assign accept = bus.req_valid & bus.req_ready;

   ysyx_23060236_btb_ram #(.IDX_W(IDX_W), .DATA_W(DATA_W)) u_ram (
      .clock (clock),
      .we    (upd_we),
      .widx  (wr_idx),
      .wdata ({wr_tag, bus.upd_target}),
      .ridx  (rd_idx),
      .rdata (rd_data)
   );

   assign hit_raw = valid_q[rd_idx] & (rd_data[DATA_W-1:32] == rd_tag);

`ifdef YSYX_23060236_BTB_BYPASS_EN
   logic byp;
   assign byp    = upd_we & (wr_idx == rd_idx) & (wr_tag == rd_tag);
   assign hit    = byp | hit_raw;
   assign target = byp ? bus.upd_target : (hit_raw ? rd_data[31:0] : 32'h0);
`else
   assign hit    = hit_raw;
   assign target = hit_raw ? rd_data[31:0] : 32'h0;
`endif

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      case (state_q)
         BTB_CLEAR: begin
            if (bus.flush) begin
               clr_idx_d = '0;
            end else if (&clr_idx_q) begin
               state_d   = BTB_IDLE;
               clr_idx_d = '0;
            end else begin
               clr_idx_d = clr_idx_q + 1'b1;
            end
         end
         default: begin
            if (bus.flush) begin
               state_d   = BTB_CLEAR;
               clr_idx_d = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q         <= BTB_CLEAR;
         clr_idx_q       <= '0;
         bus.resp_valid  <= 1'b0;
         bus.resp_hit    <= 1'b0;
         bus.resp_target <= 32'h0;
      end else begin
         state_q        <= state_d;
         clr_idx_q      <= clr_idx_d;
         bus.resp_valid <= accept;
         if (accept) begin
            bus.resp_hit    <= hit;
            bus.resp_target <= target;
         end
      end
   end

   // Valid bits need no reset: the sweep clears them before IDLE is reached.
   always_ff @(posedge clock) begin
      if (state_q == BTB_CLEAR) valid_q[clr_idx_q] <= 1'b0;
      else if (upd_we)          valid_q[wr_idx]    <= 1'b1;
   end

   assign bus.req_ready = (state_q == BTB_IDLE);
   assign bus.busy      = (state_q == BTB_CLEAR);
endmodule

// File: tb/tb_ysyx_23060236_btb.sv
module tb_ysyx_23060236_btb;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;

   ysyx_23060236_btb_if #(.ADDR_W(25)) bus ();

   ysyx_23060236_btb dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic lookup(input logic [24:0] pc, input logic exp_hit,
                         input logic [31:0] exp_tgt, input string tag);
      bus.req_valid = 1'b1;
      bus.req_pc    = pc;
      tick();
      bus.req_valid = 1'b0;
      chk({tag, ".valid"}, {31'h0, bus.resp_valid}, 32'h1);
      chk({tag, ".hit"},   {31'h0, bus.resp_hit},   {31'h0, exp_hit});
      chk({tag, ".tgt"},   bus.resp_target,         exp_tgt);
   endtask

   task automatic update(input logic [24:0] pc, input logic [31:0] tgt);
      bus.upd_valid  = 1'b1;
      bus.upd_pc     = pc;
      bus.upd_target = tgt;
      tick();
      bus.upd_valid  = 1'b0;
   endtask

   // counts edges until busy drops; bounded so a stuck sweep still finishes
   task automatic wait_idle(output int n);
      n = 0;
      while (bus.busy && n < 200) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n, total;
      bus.req_valid  = 1'b0;
      bus.req_pc     = '0;
      bus.upd_valid  = 1'b0;
      bus.upd_pc     = '0;
      bus.upd_target = '0;
      bus.flush      = 1'b0;

      // reset values
      tick(); tick();
      chk("rst.resp_valid", {31'h0, bus.resp_valid}, 32'h0);
      chk("rst.resp_hit",   {31'h0, bus.resp_hit},   32'h0);
      chk("rst.resp_tgt",   bus.resp_target,         32'h0);
      chk("rst.busy",       {31'h0, bus.busy},       32'h1);
      chk("rst.ready",      {31'h0, bus.req_ready},  32'h0);
      reset = 1'b0;
      wait_idle(n);
      chk("rst.sweep_len", n, 16);
      chk("idle.ready", {31'h0, bus.req_ready}, 32'h1);
      chk("idle.busy",  {31'h0, bus.busy},      32'h0);

      // miss then hit
      lookup(25'h0000100, 1'b0, 32'h0, "miss");
      tick();
      chk("resp_drop", {31'h0, bus.resp_valid}, 32'h0);
      update(25'h0000100, 32'h800000F0);
      lookup(25'h0000100, 1'b1, 32'h800000F0, "hit");

      // alias: same index 0, tag 5 vs tag 4
      lookup(25'h0000140, 1'b0, 32'h0, "alias_miss");
      update(25'h0000140, 32'h80000010);
      lookup(25'h0000100, 1'b0, 32'h0, "alias_evict");
      lookup(25'h0000140, 1'b1, 32'h80000010, "alias_hit");

      // same-cycle lookup and update to 0x200
      bus.upd_valid  = 1'b1;
      bus.upd_pc     = 25'h0000200;
      bus.upd_target = 32'h80000200;
`ifdef YSYX_23060236_BTB_BYPASS_EN
      lookup(25'h0000200, 1'b1, 32'h80000200, "same_cycle");
`else
      lookup(25'h0000200, 1'b0, 32'h0, "same_cycle");
`endif
      bus.upd_valid = 1'b0;
      lookup(25'h0000200, 1'b1, 32'h80000200, "after_same");

      // fill every index, then flush with a colliding update
      for (int i = 0; i < 16; i++) update(25'h0000300 + 25'(i * 4), 32'h90000000 + i);
      lookup(25'h0000314, 1'b1, 32'h90000005, "fill5");
      bus.flush      = 1'b1;
      bus.upd_valid  = 1'b1;
      bus.upd_pc     = 25'h0000404;
      bus.upd_target = 32'hDEAD0000;
      bus.req_valid  = 1'b1;
      bus.req_pc     = 25'h000031C;
      tick();
      bus.flush     = 1'b0;
      bus.upd_valid = 1'b0;
      bus.req_valid = 1'b0;
      chk("flush_lookup.valid", {31'h0, bus.resp_valid}, 32'h1);
      chk("flush_lookup.tgt",   bus.resp_target,         32'h90000007);
      chk("flush.busy", {31'h0, bus.busy}, 32'h1);
      wait_idle(n);
      chk("flush.sweep_len", n, 16);
      for (int i = 0; i < 16; i++) lookup(25'h0000300 + 25'(i * 4), 1'b0, 32'h0, "post_flush");
      lookup(25'h0000404, 1'b0, 32'h0, "flush_upd_dropped");

      // update during sweep is dropped; second flush restarts the sweep
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      total = 1;
      for (int i = 0; i < 7; i++) begin
         if (i == 2) begin
            bus.upd_valid  = 1'b1;
            bus.upd_pc     = 25'h0000500;
            bus.upd_target = 32'h12345678;
         end
         tick();
         bus.upd_valid = 1'b0;
         total++;
      end
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      total++;
      wait_idle(n);
      total += n - 1;
      chk("reflush.busy_cycles", total, 24);
      lookup(25'h0000500, 1'b0, 32'h0, "clear_upd_dropped");

      // reset right after an accepted lookup
      update(25'h0000600, 32'hABCD0000);
      lookup(25'h0000600, 1'b1, 32'hABCD0000, "pre_reset");
      reset = 1'b1;
      #1;
      chk("midrst.resp_valid", {31'h0, bus.resp_valid}, 32'h0);
      chk("midrst.resp_hit",   {31'h0, bus.resp_hit},   32'h0);
      chk("midrst.busy",       {31'h0, bus.busy},       32'h1);
      chk("midrst.ready",      {31'h0, bus.req_ready},  32'h0);
      tick();
      reset = 1'b0;
      wait_idle(n);
      chk("midrst.sweep_len", n, 16);
      lookup(25'h0000600, 1'b0, 32'h0, "post_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ysyx_23060236_btb.md
Name: ysyx_23060236_btb

Overview:
- Direct-mapped branch target buffer between the execute stage and instruction fetch.
- Execute writes a target whenever a taken backward branch or a jal was mispredicted.
- Fetch looks up each fetch PC and receives a predicted next PC one cycle later.
- Entries are invalidated by a sequential sweep after reset and on flush requests.

Parameters:
- ADDR_W, 25, number of PC bits stored and compared; matches the execute-stage pc_next width.
- IDX_W, 4, index bits; the table has 2^IDX_W entries.
- TAG_W, ADDR_W-2-IDX_W, derived tag width; 19 at defaults.

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  fetch lookup request
- req_ready  out  1  lookup can be accepted this cycle
- req_pc  in  ADDR_W  fetch PC, low bits
- resp_valid  out  1  lookup result valid, one cycle after acceptance
- resp_hit  out  1  entry valid and tag matched
- resp_target  out  32  predicted target; 0 when resp_hit=0
- upd_valid  in  1  update strobe from execute (btb_wvalid)
- upd_pc  in  ADDR_W  branch PC (pc_next)
- upd_target  in  32  resolved target (jump_addr)
- flush  in  1  invalidate all entries
- busy  out  1  clear sweep in progress

Behaviour:
- Index is pc[IDX_W+1:2]; tag is pc[ADDR_W-1:IDX_W+2]; pc[1:0] ignored.
- Storage per entry: valid bit, TAG_W tag, 32-bit target. Targets and tags need no reset; valid bits are cleared by the sweep.
- FSM states:
  - CLEAR: clr_idx counts 0..2^IDX_W-1, clearing valid[clr_idx] one entry per cycle. After the last index, go to IDLE.
  - IDLE: normal operation.
- Reset (asynchronous) forces CLEAR with clr_idx=0 and sets resp_valid=0, resp_hit=0, resp_target=0, busy=1, req_ready=0. A sweep therefore takes 2^IDX_W cycles (16 at defaults).
- busy=1 and req_ready=0 in CLEAR; busy=0 and req_ready=1 in IDLE.
- Lookup:
  - Accepted when req_valid & req_ready.
  - In the next cycle resp_valid=1, resp_hit = valid[idx] & (tag==stored tag), and resp_target = stored target if hit, else 0.
  - resp_valid deasserts in the cycle after no acceptance. No stall: fetch must consume the response in that cycle.
- Update:
  - In IDLE, upd_valid writes valid=1, tag and target at the index at the clock edge, overwriting any existing entry.
  - In CLEAR, updates are dropped.
- Flush:
  - In IDLE, flush moves to CLEAR with clr_idx=0 next cycle. A lookup accepted in the same cycle still gets its response.
  - In CLEAR, flush restarts the sweep at clr_idx=0.
- Simultaneous events in IDLE:
  - flush + upd_valid in the same cycle: flush wins, update discarded.
  - Lookup and update to the same index in the same cycle: the lookup returns pre-update contents (see Optional Feature).
- Response registers are updated only on acceptance or reset.

Optional Feature:
- Macro: YSYX_23060236_BTB_BYPASS_EN.
- Defined: a lookup accepted in the same cycle as an IDLE update with matching index and tag returns resp_hit=1 and resp_target=upd_target.
- Undefined: that lookup returns the old entry contents. This is the default and saves one comparator on the fetch path.

Decomposition:
- Shared defines: state encodings (BTB_IDLE=1'b0, BTB_CLEAR=1'b1) and the default IDX_W/ADDR_W values, kept alongside the existing core-wide defines.
- Sub-module ysyx_23060236_btb_ram: entry array with one synchronous-write port and one combinational-read port, no reset. The top level holds the valid vector, FSM, sweep counter, response registers and bypass logic.

Test Plan:
- Reset sequence: assert reset, release; busy=1 and req_ready=0 for exactly 16 cycles, then busy=0 and req_ready=1. All outputs are 0 during reset.
- Miss then hit: lookup 0x0000100 gives resp_hit=0 and resp_target=0. Then update pc=0x0000100, target=0x800000F0. Lookup 0x0000100 next cycle gives resp_hit=1, resp_target=0x800000F0.
- Alias: after the entry above, lookup 0x0000140 (same index, different tag) gives resp_hit=0. Update 0x0000140 → 0x80000010; lookup 0x0000100 now gives resp_hit=0.
- Same-cycle lookup+update to 0x0000200 → 0x80000200:
  - Without the macro: resp_hit=0.
  - With YSYX_23060236_BTB_BYPASS_EN: resp_hit=1, resp_target=0x80000200.
- Flush: fill indices 0..15, pulse flush with a same-cycle update. Busy for 16 cycles, then every lookup misses and the update is absent. A second flush at sweep cycle 8 extends busy to 8+16 cycles.
- Reset mid-sweep and mid-lookup: reset asserted one cycle after an accepted lookup forces resp_valid=0 immediately and restarts the 16-cycle sweep.
